// File: rtl/hit_resolver_if.sv
// Purpose: groups the collision-result inputs and the fight-status outputs of hit_resolver.
// Latency: none, wiring only.
// Backpressure: none; all inputs are levels or 1-cycle pulses sampled every clock.
interface hit_resolver_if;
    // Inputs to the resolver
    logic       frame_tick;
    logic       p1_got_hit;
    logic       p1_got_blocked;
    logic       p2_got_hit;
    logic       p2_got_blocked;
    logic       p1_atk_start;
    logic       p2_atk_start;
    logic       round_reset;
    // Outputs from the resolver
    logic       freeze;
    logic       p1_stun;
    logic       p1_blockstun;
    logic       p2_stun;
    logic       p2_blockstun;
    logic [1:0] p1_score;
    logic [1:0] p2_score;
    logic       hit_pulse;
    logic       block_pulse;
    logic       round_over;
    logic       winner;

    // Driver side: collision checks, attack FSMs and round control
    modport master (
        output frame_tick, p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked,
               p1_atk_start, p2_atk_start, round_reset,
        input  freeze, p1_stun, p1_blockstun, p2_stun, p2_blockstun,
               p1_score, p2_score, hit_pulse, block_pulse, round_over, winner
    );

    // Resolver side
    modport slave (
        input  frame_tick, p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked,
               p1_atk_start, p2_atk_start, round_reset,
        output freeze, p1_stun, p1_blockstun, p2_stun, p2_blockstun,
               p1_score, p2_score, hit_pulse, block_pulse, round_over, winner
    );
endinterface

// File: rtl/hit_resolver.sv
// Purpose: turns per-target collision results into one accepted hit per attack, hitstop, stun timers, score and KO.
// Latency: accepted event shows on outputs 1 clk later; timers advance only on frame_tick.
// Backpressure: none; events arriving in HITSTOP/KO or from a disarmed attacker are dropped.
module hit_resolver #(
    parameter int HITSTOP_FRAMES   = 6,
    parameter int HITSTUN_FRAMES   = 20,
    parameter int BLOCKSTUN_FRAMES = 12,
    parameter int WIN_HITS         = 3,
    parameter int CNT_W            = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    hit_resolver_if.slave bus
);

    typedef enum logic [1:0] {
        ST_FIGHT   = 2'd0,
        ST_HITSTOP = 2'd1,
        ST_STUN    = 2'd2,
        ST_KO      = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HS_LD = CNT_W'(HITSTOP_FRAMES);
    localparam logic [CNT_W-1:0] HT_LD = CNT_W'(HITSTUN_FRAMES);
    localparam logic [CNT_W-1:0] BS_LD = CNT_W'(BLOCKSTUN_FRAMES);
    localparam logic [1:0]       WIN_SC = 2'(WIN_HITS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hs_cnt_q, hs_cnt_d;
    logic [CNT_W-1:0] p1_cnt_q, p1_cnt_d;
    logic [CNT_W-1:0] p2_cnt_q, p2_cnt_d;
    logic             p1_blk_q, p1_blk_d;
    logic             p2_blk_q, p2_blk_d;
    logic [1:0]       p1_score_q, p1_score_d;
    logic [1:0]       p2_score_q, p2_score_d;
    logic             p1_armed_q, p1_armed_d;
    logic             p2_armed_q, p2_armed_d;
    logic             hit_pulse_q, hit_pulse_d;
    logic             block_pulse_q, block_pulse_d;

    // Acceptance decode. pX_acc means "player X as a target takes an event this cycle".
    logic             acc_en;
    logic             p1_acc, p2_acc, any_acc, trade;
    logic             p1_load_hit, p2_load_hit;
    logic             any_win, hs_done;
    logic [CNT_W-1:0] p1_cnt_dec, p2_cnt_dec;

    assign acc_en  = ((state_q == ST_FIGHT) || (state_q == ST_STUN)) && !bus.round_reset;
    // P1 is struck by P2's attack, so P2's arm gates it (and vice versa)
    assign p1_acc  = acc_en && p2_armed_q && (bus.p1_got_hit || bus.p2_got_hit & 1'b0 || bus.p1_got_blocked);
    assign p2_acc  = acc_en && p1_armed_q && (bus.p2_got_hit || bus.p2_got_blocked);
    assign any_acc = p1_acc || p2_acc;
    assign trade   = p1_acc && p2_acc;

    // A trade always means hitstun on both sides; otherwise got_hit beats got_blocked
    assign p1_load_hit = trade || bus.p1_got_hit;
    assign p2_load_hit = trade || bus.p2_got_hit;

    assign any_win = (p1_score_q == WIN_SC) || (p2_score_q == WIN_SC);
    // Last hitstop tick; "<= ONE" also covers a zero-length hitstop configuration
    assign hs_done = (state_q == ST_HITSTOP) && bus.frame_tick && (hs_cnt_q <= ONE);

    assign p1_cnt_dec = (bus.frame_tick && (p1_cnt_q != '0)) ? (p1_cnt_q - ONE) : p1_cnt_q;
    assign p2_cnt_dec = (bus.frame_tick && (p2_cnt_q != '0)) ? (p2_cnt_q - ONE) : p2_cnt_q;

    // Next fight phase; round_reset overrides everything, including a same-cycle hit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FIGHT: begin
                if (any_acc) state_d = ST_HITSTOP;
            end
            ST_HITSTOP: begin
                if (hs_done) state_d = any_win ? ST_KO : ST_STUN;
            end
            ST_STUN: begin
                if (any_acc) begin
                    state_d = ST_HITSTOP;
                end else if ((p1_cnt_dec == '0) && (p2_cnt_dec == '0)) begin
                    state_d = ST_FIGHT;
                end
            end
            ST_KO: begin
                state_d = ST_KO;
            end
        endcase
        if (bus.round_reset) state_d = ST_FIGHT;
    end

    // Hitstop counter: loaded on accept (tick that cycle is ignored), counts frames while frozen
    always_comb begin
        hs_cnt_d = hs_cnt_q;
        if (any_acc) begin
            hs_cnt_d = HS_LD;
        end else if ((state_q == ST_HITSTOP) && bus.frame_tick) begin
            hs_cnt_d = hs_done ? '0 : (hs_cnt_q - ONE);
        end
        if (bus.round_reset) hs_cnt_d = '0;
    end

    // P1 stun timer and its block/hit qualifier; a re-hit reloads rather than accumulates
    always_comb begin
        p1_cnt_d = p1_cnt_q;
        p1_blk_d = p1_blk_q;
        if (state_q == ST_STUN) p1_cnt_d = p1_cnt_dec;
        if (hs_done && any_win) p1_cnt_d = '0;
        if (p1_acc) begin
            p1_cnt_d = p1_load_hit ? HT_LD : BS_LD;
            p1_blk_d = !p1_load_hit;
        end
        if (bus.round_reset) begin
            p1_cnt_d = '0;
            p1_blk_d = 1'b0;
        end
    end

    // P2 stun timer, mirror of P1
    always_comb begin
        p2_cnt_d = p2_cnt_q;
        p2_blk_d = p2_blk_q;
        if (state_q == ST_STUN) p2_cnt_d = p2_cnt_dec;
        if (hs_done && any_win) p2_cnt_d = '0;
        if (p2_acc) begin
            p2_cnt_d = p2_load_hit ? HT_LD : BS_LD;
            p2_blk_d = !p2_load_hit;
        end
        if (bus.round_reset) begin
            p2_cnt_d = '0;
            p2_blk_d = 1'b0;
        end
    end

    // Scores: a single clean hit credits the attacker, saturating; trades and blocks score nothing
    always_comb begin
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        if (!trade) begin
            if (p2_acc && bus.p2_got_hit && (p1_score_q != WIN_SC)) p1_score_d = p1_score_q + 2'd1;
            if (p1_acc && bus.p1_got_hit && (p2_score_q != WIN_SC)) p2_score_d = p2_score_q + 2'd1;
        end
        if (bus.round_reset) begin
            p1_score_d = '0;
            p2_score_d = '0;
        end
    end

    // Arming: one accepted event per attack; a new attack start re-arms even on a same-cycle accept
    always_comb begin
        p1_armed_d = p1_armed_q;
        p2_armed_d = p2_armed_q;
        if (p2_acc) p1_armed_d = 1'b0;
        if (p1_acc) p2_armed_d = 1'b0;
        if (bus.p1_atk_start) p1_armed_d = 1'b1;
        if (bus.p2_atk_start) p2_armed_d = 1'b1;
        if (bus.round_reset) begin
            p1_armed_d = 1'b1;
            p2_armed_d = 1'b1;
        end
    end

    // Effect pulses: any clean hit (including a trade) gives one hit_pulse, otherwise a block_pulse
    always_comb begin
        hit_pulse_d   = trade || (p1_acc && bus.p1_got_hit) || (p2_acc && bus.p2_got_hit);
        block_pulse_d = any_acc && !hit_pulse_d;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FIGHT;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, flags, scores, arming and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_cnt_q      <= '0;
            p1_cnt_q      <= '0;
            p2_cnt_q      <= '0;
            p1_blk_q      <= 1'b0;
            p2_blk_q      <= 1'b0;
            p1_score_q    <= '0;
            p2_score_q    <= '0;
            p1_armed_q    <= 1'b1;
            p2_armed_q    <= 1'b1;
            hit_pulse_q   <= 1'b0;
            block_pulse_q <= 1'b0;
        end else begin
            hs_cnt_q      <= hs_cnt_d;
            p1_cnt_q      <= p1_cnt_d;
            p2_cnt_q      <= p2_cnt_d;
            p1_blk_q      <= p1_blk_d;
            p2_blk_q      <= p2_blk_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            p1_armed_q    <= p1_armed_d;
            p2_armed_q    <= p2_armed_d;
            hit_pulse_q   <= hit_pulse_d;
            block_pulse_q <= block_pulse_d;
        end
    end

    // Outputs come straight from registers; stun counters are already cleared on entering KO
    assign bus.freeze       = (state_q == ST_HITSTOP);
    assign bus.p1_stun      = (p1_cnt_q != '0);
    assign bus.p1_blockstun = (p1_cnt_q != '0) && p1_blk_q;
    assign bus.p2_stun      = (p2_cnt_q != '0);
    assign bus.p2_blockstun = (p2_cnt_q != '0) && p2_blk_q;
    assign bus.p1_score     = p1_score_q;
    assign bus.p2_score     = p2_score_q;
    assign bus.hit_pulse    = hit_pulse_q;
    assign bus.block_pulse  = block_pulse_q;
    assign bus.round_over   = (state_q == ST_KO);
    // P1 wins ties, so the winner bit is 1 only when P1 has not reached the winning score
    assign bus.winner       = (state_q == ST_KO) && (p1_score_q != WIN_SC);

endmodule

// File: tb/tb_hit_resolver.sv
module tb_hit_resolver;
    localparam int HS  = 6;
    localparam int HT  = 20;
    localparam int BS  = 12;
    localparam int WIN = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hit_resolver_if bus();

    hit_resolver #(
        .HITSTOP_FRAMES(HS), .HITSTUN_FRAMES(HT), .BLOCKSTUN_FRAMES(BS),
        .WIN_HITS(WIN), .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: frames left in freeze, frames left of stun per player, scores, arms.
    // The fight phase is implied: KO flag, else freeze>0, else any stun>0, else fighting.
    int m_hs;
    int m_cnt[2];
    int m_score[2];
    bit m_blk[2];
    bit m_armed[2];
    bit m_ko;
    bit m_hp;
    bit m_bp;

    task automatic model_reset();
        m_hs = 0; m_ko = 0; m_hp = 0; m_bp = 0;
        for (int t = 0; t < 2; t++) begin
            m_cnt[t] = 0; m_score[t] = 0; m_blk[t] = 0; m_armed[t] = 1;
        end
    endtask

    task automatic model_step();
        bit gh[2], gb[2], st[2], acc[2];
        gh[0] = bus.p1_got_hit; gb[0] = bus.p1_got_blocked; st[0] = bus.p1_atk_start;
        gh[1] = bus.p2_got_hit; gb[1] = bus.p2_got_blocked; st[1] = bus.p2_atk_start;
        if (bus.round_reset) begin
            model_reset();
            return;
        end
        m_hp = 0; m_bp = 0;
        for (int t = 0; t < 2; t++)
            acc[t] = !m_ko && (m_hs == 0) && m_armed[1-t] && (gh[t] || gb[t]);
        if (bus.frame_tick) begin
            if (m_hs > 0) begin
                m_hs--;
                if (m_hs == 0 && (m_score[0] == WIN || m_score[1] == WIN)) begin
                    m_ko = 1; m_cnt[0] = 0; m_cnt[1] = 0;
                end
            end else if (!m_ko) begin
                for (int t = 0; t < 2; t++) if (m_cnt[t] > 0) m_cnt[t]--;
            end
        end
        if (acc[0] && acc[1]) begin
            for (int t = 0; t < 2; t++) begin m_cnt[t] = HT; m_blk[t] = 0; end
            m_hp = 1; m_hs = HS;
        end else begin
            for (int t = 0; t < 2; t++) if (acc[t]) begin
                m_hs = HS;
                if (gh[t]) begin
                    m_cnt[t] = HT; m_blk[t] = 0; m_hp = 1;
                    if (m_score[1-t] < WIN) m_score[1-t]++;
                end else begin
                    m_cnt[t] = BS; m_blk[t] = 1; m_bp = 1;
                end
            end
        end
        for (int t = 0; t < 2; t++) if (acc[t]) m_armed[1-t] = 0;
        for (int t = 0; t < 2; t++) if (st[t]) m_armed[t] = 1;
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs are read 1 ns after the edge
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1();
        bus.frame_tick = 1'b1; cyc();
        bus.frame_tick = 1'b0; cyc();
    endtask

    task automatic clear_inputs();
        bus.frame_tick = 0; bus.p1_got_hit = 0; bus.p1_got_blocked = 0;
        bus.p2_got_hit = 0; bus.p2_got_blocked = 0; bus.p1_atk_start = 0;
        bus.p2_atk_start = 0; bus.round_reset = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    // Frame ticks issued until freeze drops (bounded)
    task automatic ticks_while_freeze(output int n);
        n = 0;
        while (bus.freeze === 1'b1 && n < 100) begin tick1(); n++; end
    endtask

    // Frame ticks issued until the selected stun drops: 0=P1, 1=P2, 2=either (bounded)
    task automatic ticks_while_stun(input int who, output int n);
        n = 0;
        while (n < 100 && ((who == 0) ? bus.p1_stun === 1'b1 :
                           (who == 1) ? bus.p2_stun === 1'b1 :
                           (bus.p1_stun === 1'b1 || bus.p2_stun === 1'b1))) begin
            tick1(); n++;
        end
    endtask

    task automatic test_reset();
        logic [12:0] outs;
        do_reset();
        outs = {bus.freeze, bus.p1_stun, bus.p1_blockstun, bus.p2_stun, bus.p2_blockstun,
                bus.p1_score, bus.p2_score, bus.hit_pulse, bus.block_pulse, bus.round_over, bus.winner};
        checks++;
        if (outs !== 13'd0) begin errors++; $display("FAIL reset_outputs got=%b exp=0", outs); end
        repeat (3) tick1();
        checks++;
        if ({bus.freeze, bus.hit_pulse, bus.round_over} !== 3'b000) begin
            errors++; $display("FAIL reset_idle got=%b exp=000", {bus.freeze, bus.hit_pulse, bus.round_over});
        end
    endtask

    task automatic test_clean_hit();
        int pulses, n;
        do_reset();
        pulses = 0;
        bus.p1_got_hit = 1;
        for (int i = 0; i < 10; i++) begin cyc(); if (bus.hit_pulse === 1'b1) pulses++; end
        bus.p1_got_hit = 0;
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL hit_single_pulse got=%0d exp=1", pulses); end
        checks++;
        if ({bus.p1_score, bus.p2_score} !== {2'd0, 2'd1}) begin
            errors++; $display("FAIL hit_score got=%0d/%0d exp=0/1", bus.p1_score, bus.p2_score);
        end
        ticks_while_freeze(n);
        checks++;
        if (n != HS) begin errors++; $display("FAIL hit_freeze_ticks got=%0d exp=%0d", n, HS); end
        checks++;
        if ({bus.p1_stun, bus.p1_blockstun} !== 2'b10) begin
            errors++; $display("FAIL hit_stun_kind got=%b exp=10", {bus.p1_stun, bus.p1_blockstun});
        end
        ticks_while_stun(0, n);
        checks++;
        if (n != HT) begin errors++; $display("FAIL hitstun_ticks got=%0d exp=%0d", n, HT); end
    endtask

    task automatic test_block();
        int n;
        bus.p2_got_blocked = 1; cyc(); bus.p2_got_blocked = 0;
        checks++;
        if ({bus.hit_pulse, bus.block_pulse} !== 2'b01) begin
            errors++; $display("FAIL block_pulse got=%b exp=01", {bus.hit_pulse, bus.block_pulse});
        end
        cyc();
        checks++;
        if (bus.block_pulse !== 1'b0) begin errors++; $display("FAIL block_pulse_width got=1 exp=0"); end
        checks++;
        if ({bus.p1_score, bus.p2_score} !== {2'd0, 2'd1}) begin
            errors++; $display("FAIL block_score got=%0d/%0d exp=0/1", bus.p1_score, bus.p2_score);
        end
        ticks_while_freeze(n);
        checks++;
        if (n != HS) begin errors++; $display("FAIL block_freeze_ticks got=%0d exp=%0d", n, HS); end
        checks++;
        if ({bus.p2_stun, bus.p2_blockstun} !== 2'b11) begin
            errors++; $display("FAIL block_stun_kind got=%b exp=11", {bus.p2_stun, bus.p2_blockstun});
        end
        ticks_while_stun(1, n);
        checks++;
        if (n != BS) begin errors++; $display("FAIL blockstun_ticks got=%0d exp=%0d", n, BS); end
    endtask

    task automatic test_trade();
        int pulses, n;
        do_reset();
        bus.p1_got_hit = 1; bus.p2_got_hit = 1; cyc();
        bus.p1_got_hit = 0; bus.p2_got_hit = 0;
        checks++;
        if ({bus.hit_pulse, bus.block_pulse} !== 2'b10) begin
            errors++; $display("FAIL trade_pulse got=%b exp=10", {bus.hit_pulse, bus.block_pulse});
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin cyc(); if (bus.hit_pulse === 1'b1) pulses++; end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL trade_extra_pulses got=%0d exp=0", pulses); end
        checks++;
        if ({bus.p1_score, bus.p2_score} !== 4'd0) begin
            errors++; $display("FAIL trade_score got=%0d/%0d exp=0/0", bus.p1_score, bus.p2_score);
        end
        ticks_while_freeze(n);
        checks++;
        if ({bus.p1_stun, bus.p1_blockstun, bus.p2_stun, bus.p2_blockstun} !== 4'b1010) begin
            errors++; $display("FAIL trade_stun got=%b exp=1010",
                               {bus.p1_stun, bus.p1_blockstun, bus.p2_stun, bus.p2_blockstun});
        end
        ticks_while_stun(2, n);
        checks++;
        if (n != HT) begin errors++; $display("FAIL trade_stun_ticks got=%0d exp=%0d", n, HT); end
    endtask

    task automatic test_rehit();
        int pulses, n;
        do_reset();
        bus.p1_got_hit = 1; cyc(); bus.p1_got_hit = 0;
        ticks_while_freeze(n);
        repeat (5) tick1();
        pulses = 0;
        bus.p1_got_hit = 1;
        for (int i = 0; i < 3; i++) begin cyc(); if (bus.hit_pulse === 1'b1) pulses++; end
        checks++;
        if (pulses != 0 || bus.p2_score !== 2'd1) begin
            errors++; $display("FAIL disarmed_ignored pulses=%0d score=%0d exp=0/1", pulses, bus.p2_score);
        end
        bus.p2_atk_start = 1; cyc(); bus.p2_atk_start = 0;
        cyc();
        bus.p1_got_hit = 0;
        checks++;
        if (bus.hit_pulse !== 1'b1 || bus.p2_score !== 2'd2) begin
            errors++; $display("FAIL rearm_hit pulse=%b score=%0d exp=1/2", bus.hit_pulse, bus.p2_score);
        end
        ticks_while_freeze(n);
        ticks_while_stun(0, n);
        checks++;
        if (n != HT) begin errors++; $display("FAIL rehit_reload_ticks got=%0d exp=%0d", n, HT); end
    endtask

    task automatic test_ko();
        int n;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.p1_atk_start = 1; cyc(); bus.p1_atk_start = 0;
            bus.p2_got_hit = 1; cyc(); bus.p2_got_hit = 0;
            ticks_while_freeze(n);
            if (k < 2) ticks_while_stun(1, n);
        end
        checks++;
        if ({bus.round_over, bus.winner, bus.p1_score} !== {1'b1, 1'b0, 2'd3}) begin
            errors++; $display("FAIL ko_state over=%b winner=%b p1=%0d exp=1/0/3",
                               bus.round_over, bus.winner, bus.p1_score);
        end
        checks++;
        if ({bus.freeze, bus.p2_stun} !== 2'b00) begin
            errors++; $display("FAIL ko_outputs got=%b exp=00", {bus.freeze, bus.p2_stun});
        end
        bus.p1_atk_start = 1; cyc(); bus.p1_atk_start = 0;
        bus.p2_got_hit = 1; cyc(); bus.p2_got_hit = 0;
        tick1();
        checks++;
        if (bus.round_over !== 1'b1 || bus.hit_pulse !== 1'b0 || bus.p1_score !== 2'd3) begin
            errors++; $display("FAIL ko_holds over=%b pulse=%b p1=%0d exp=1/0/3",
                               bus.round_over, bus.hit_pulse, bus.p1_score);
        end
        bus.round_reset = 1; cyc(); bus.round_reset = 0;
        checks++;
        if ({bus.round_over, bus.p1_score, bus.p2_score, bus.freeze} !== 6'd0) begin
            errors++; $display("FAIL round_reset got over=%b p1=%0d p2=%0d fr=%b exp=0",
                               bus.round_over, bus.p1_score, bus.p2_score, bus.freeze);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.p1_got_hit = 1; cyc(); bus.p1_got_hit = 0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.freeze, bus.p2_score, bus.hit_pulse, bus.p1_stun} !== 5'd0) begin
            errors++; $display("FAIL async_reset fr=%b p2=%0d pulse=%b stun=%b exp=0",
                               bus.freeze, bus.p2_score, bus.hit_pulse, bus.p1_stun);
        end
        model_reset();
        #2 rst_n = 1'b1;
        bus.round_reset = 1; bus.p2_got_hit = 1; cyc();
        bus.round_reset = 0; bus.p2_got_hit = 0;
        checks++;
        if ({bus.hit_pulse, bus.p1_score, bus.freeze} !== 4'd0) begin
            errors++; $display("FAIL reset_beats_hit pulse=%b p1=%0d fr=%b exp=0",
                               bus.hit_pulse, bus.p1_score, bus.freeze);
        end
        bus.p2_got_hit = 1; cyc(); bus.p2_got_hit = 0;
        checks++;
        if (bus.p1_score !== 2'd1) begin
            errors++; $display("FAIL armed_after_reset p1=%0d exp=1", bus.p1_score);
        end
    endtask

    task automatic test_random();
        logic [12:0] act, exp;
        bit s1, s2;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bus.frame_tick     = ($urandom_range(0, 2) == 0);
            bus.p1_got_hit     = ($urandom_range(0, 5) == 0);
            bus.p1_got_blocked = ($urandom_range(0, 5) == 0);
            bus.p2_got_hit     = ($urandom_range(0, 5) == 0);
            bus.p2_got_blocked = ($urandom_range(0, 5) == 0);
            bus.p1_atk_start   = ($urandom_range(0, 7) == 0);
            bus.p2_atk_start   = ($urandom_range(0, 7) == 0);
            bus.round_reset    = ($urandom_range(0, 299) == 0);
            cyc();
            s1 = !m_ko && (m_cnt[0] != 0);
            s2 = !m_ko && (m_cnt[1] != 0);
            exp = {m_hs != 0, s1, s1 && m_blk[0], s2, s2 && m_blk[1],
                   2'(m_score[0]), 2'(m_score[1]), m_hp, m_bp, m_ko,
                   m_ko && (m_score[0] != WIN)};
            act = {bus.freeze, bus.p1_stun, bus.p1_blockstun, bus.p2_stun, bus.p2_blockstun,
                   bus.p1_score, bus.p2_score, bus.hit_pulse, bus.block_pulse, bus.round_over, bus.winner};
            checks++;
            if (act !== exp) begin
                errors++; $display("FAIL random_cycle_%0d got=%b exp=%b", i, act, exp);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_clean_hit();
        test_block();
        test_trade();
        test_rehit();
        test_ko();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
